// File: rtl/sonar_array.sv
// Round-robin multi-channel ultrasonic ranger: triggers one sensor per slot, times its echo, flags near objects.
// Optional build macro SONAR_MEDIAN_EN adds a per-channel 3-sample median filter on reported widths.
module sonar_array #(
  parameter int NUM_CH         = 4,
  parameter int CNT_W          = 22,
  parameter int TRIG_CYCLES    = 512,
  parameter int PERIOD_CYCLES  = 4194304,
  parameter int TIMEOUT_CYCLES = 1900000,
  parameter int HOLD_CYCLES    = 33
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [CNT_W-1:0]  thresh,
  input  logic [NUM_CH-1:0] echo,
  output logic [NUM_CH-1:0] trig_n,
  output logic              meas_valid,
  output logic [2:0]        meas_ch,
  output logic [CNT_W-1:0]  meas_width,
  output logic              meas_timeout,
  output logic [NUM_CH-1:0] near,
  output logic              any_near
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] ALL_ONES = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_RISE = 3'd2,
    MEASURE   = 3'd3,
    GAP       = 3'd4
  } state_t;

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  sc_r, sc_s;
  logic [CNT_W-1:0]  wcnt_r, wcnt_s;
  logic [2:0]        ch_r, ch_s;
  logic [NUM_CH-1:0] sync1_r, echo_sync_r, echo_d_r;
  logic [NUM_CH-1:0] trig_n_r, trig_s;
  logic              meas_valid_r, meas_timeout_r;
  logic [2:0]        meas_ch_r;
  logic [CNT_W-1:0]  meas_width_r;
  logic [NUM_CH-1:0] near_r;
  logic [HOLD_W-1:0] hold_r [NUM_CH];
  logic              echo_cur_s, echo_prev_s, rise_s, fall_s;
  logic              result_s, timeout_s, near_set_s;
  logic [CNT_W-1:0]  new_w_s, res_w_s;

  // Two-flop synchroniser plus one delayed copy for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r     <= {NUM_CH{1'b0}};
      echo_sync_r <= {NUM_CH{1'b0}};
      echo_d_r    <= {NUM_CH{1'b0}};
    end else begin
      sync1_r     <= echo;
      echo_sync_r <= sync1_r;
      echo_d_r    <= echo_sync_r;
    end
  end

  // Select the synchronised echo of the active channel
  always_comb begin
    echo_cur_s  = 1'b0;
    echo_prev_s = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      echo_cur_s  = (3'(i) == ch_r) ? echo_sync_r[i] : echo_cur_s;
      echo_prev_s = (3'(i) == ch_r) ? echo_d_r[i]    : echo_prev_s;
    end
  end

  assign rise_s = echo_cur_s & ~echo_prev_s;
  assign fall_s = ~echo_cur_s & echo_prev_s;

  // Slot controller next-state logic
  always_comb begin
    state_s   = state_r;
    sc_s      = sc_r + CNT_W'(1);
    ch_s      = ch_r;
    wcnt_s    = wcnt_r;
    result_s  = 1'b0;
    timeout_s = 1'b0;
    case (state_r)
      IDLE: begin
        sc_s = {CNT_W{1'b0}};
        if (enable) state_s = TRIG;
        else        state_s = IDLE;
      end
      TRIG: begin
        if (sc_r == CNT_W'(TRIG_CYCLES - 1)) state_s = WAIT_RISE;
        else                                 state_s = TRIG;
      end
      WAIT_RISE: begin
        if (sc_r == CNT_W'(TIMEOUT_CYCLES)) begin
          state_s   = GAP;
          result_s  = 1'b1;
          timeout_s = 1'b1;
        end else if (rise_s) begin
          state_s = MEASURE;
          wcnt_s  = CNT_W'(1);
        end else begin
          state_s = WAIT_RISE;
        end
      end
      MEASURE: begin
        if (sc_r == CNT_W'(TIMEOUT_CYCLES)) begin
          state_s   = GAP;
          result_s  = 1'b1;
          timeout_s = 1'b1;
        end else if (fall_s) begin
          state_s  = GAP;
          result_s = 1'b1;
        end else if (wcnt_r != ALL_ONES) begin
          wcnt_s = wcnt_r + CNT_W'(1);
        end else begin
          wcnt_s = wcnt_r;
        end
      end
      GAP: begin
        if (sc_r == CNT_W'(PERIOD_CYCLES - 1)) begin
          sc_s    = {CNT_W{1'b0}};
          ch_s    = (ch_r == 3'(NUM_CH - 1)) ? 3'd0 : ch_r + 3'd1;
          state_s = enable ? TRIG : IDLE;
        end else begin
          state_s = GAP;
        end
      end
      default: begin
        state_s = IDLE;
        sc_s    = {CNT_W{1'b0}};
      end
    endcase
  end

  // Trigger pattern for the upcoming cycle, so trig_n can be a plain register
  always_comb begin
    trig_s = {NUM_CH{1'b1}};
    for (int i = 0; i < NUM_CH; i++) begin
      trig_s[i] = ~((state_s == TRIG) && (3'(i) == ch_s));
    end
  end

  assign new_w_s = timeout_s ? ALL_ONES : wcnt_r;

`ifdef SONAR_MEDIAN_EN
  logic [CNT_W-1:0] hist1_r [NUM_CH];
  logic [CNT_W-1:0] hist2_r [NUM_CH];
  logic [CNT_W-1:0] h1_s, h2_s;

  function automatic logic [CNT_W-1:0] med3(input logic [CNT_W-1:0] a,
                                            input logic [CNT_W-1:0] b,
                                            input logic [CNT_W-1:0] c);
    logic [CNT_W-1:0] lo, hi, mid;
    lo  = (a < b) ? a : b;
    hi  = (a < b) ? b : a;
    mid = (hi < c) ? hi : c;
    return (lo > mid) ? lo : mid;
  endfunction

  // Pick the active channel's two previous results
  always_comb begin
    h1_s = ALL_ONES;
    h2_s = ALL_ONES;
    for (int i = 0; i < NUM_CH; i++) begin
      h1_s = (3'(i) == ch_r) ? hist1_r[i] : h1_s;
      h2_s = (3'(i) == ch_r) ? hist2_r[i] : h2_s;
    end
  end

  assign res_w_s = med3(h2_s, h1_s, new_w_s);

  // Shift the new raw result into the active channel's history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        hist1_r[i] <= ALL_ONES;
        hist2_r[i] <= ALL_ONES;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (result_s && (3'(i) == ch_r)) begin
          hist2_r[i] <= hist1_r[i];
          hist1_r[i] <= new_w_s;
        end
      end
    end
  end
`else
  assign res_w_s = new_w_s;
`endif

  assign near_set_s = result_s & ~timeout_s & (res_w_s < thresh);

  // Controller state, trigger outputs and the held result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      sc_r           <= {CNT_W{1'b0}};
      ch_r           <= 3'd0;
      wcnt_r         <= {CNT_W{1'b0}};
      trig_n_r       <= {NUM_CH{1'b1}};
      meas_valid_r   <= 1'b0;
      meas_ch_r      <= 3'd0;
      meas_width_r   <= {CNT_W{1'b0}};
      meas_timeout_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      sc_r         <= sc_s;
      ch_r         <= ch_s;
      wcnt_r       <= wcnt_s;
      trig_n_r     <= trig_s;
      meas_valid_r <= result_s;
      if (result_s) begin
        meas_ch_r      <= ch_r;
        meas_width_r   <= res_w_s;
        meas_timeout_r <= timeout_s;
      end
    end
  end

  // Per-channel proximity hold timers; only a fresh near result reloads them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      near_r <= {NUM_CH{1'b0}};
      for (int i = 0; i < NUM_CH; i++) hold_r[i] <= {HOLD_W{1'b0}};
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (near_set_s && (3'(i) == ch_r)) begin
          hold_r[i] <= HOLD_W'(HOLD_CYCLES);
          near_r[i] <= 1'b1;
        end else if (hold_r[i] != {HOLD_W{1'b0}}) begin
          hold_r[i] <= hold_r[i] - HOLD_W'(1);
          near_r[i] <= (hold_r[i] != HOLD_W'(1));
        end else begin
          near_r[i] <= 1'b0;
        end
      end
    end
  end

  assign trig_n       = trig_n_r;
  assign meas_valid   = meas_valid_r;
  assign meas_ch      = meas_ch_r;
  assign meas_width   = meas_width_r;
  assign meas_timeout = meas_timeout_r;
  assign near         = near_r;
  assign any_near     = |near_r;

endmodule
